// File: rtl/fetch_sequencer_if.sv
// Handshake and bus signals between the fetch sequencer and its ROM, branch LUT,
// instruction decoder and data memory.
interface fetch_sequencer_if;
    logic        start;
    logic [8:0]  inst;
    logic        branch_en;
    logic        memory_read_en;
    logic        memory_write_en;
    logic        mem_ack;
    logic [9:0]  lut_target;
    logic [4:0]  lut_key;
    logic [9:0]  pc;
    logic        mem_req;
    logic        exec_en;
    logic        done;
    logic        fault;
    logic [15:0] cycle_count;

    modport master (
        input  start, inst, branch_en, memory_read_en, memory_write_en, mem_ack, lut_target,
        output lut_key, pc, mem_req, exec_en, done, fault, cycle_count
    );

    modport slave (
        output start, inst, branch_en, memory_read_en, memory_write_en, mem_ack, lut_target,
        input  lut_key, pc, mem_req, exec_en, done, fault, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: single-cycle retire for ALU/branch ops, stalls on data
// memory until acknowledged, and faults after 255 consecutive un-acked wait cycles.
module fetch_sequencer (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {IDLE, RUN, MEM_WAIT, HALT, FAULT} state_t;

    localparam logic [8:0] HALT_OPCODE = 9'h1FF;
    localparam logic [7:0] WAIT_LIMIT  = 8'd254;

    state_t      state;
    logic [9:0]  pc;
    logic [15:0] cycle_count;
    logic [7:0]  wait_cnt;
    logic        done;
    logic        fault;
    logic        mem_req;
    logic        exec_en;
    logic        mem_op;
    logic        halt_op;
    logic [15:0] cycle_next;

    assign mem_op     = bus.memory_read_en | bus.memory_write_en;
    assign halt_op    = (bus.inst == HALT_OPCODE);
    assign cycle_next = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;

    // Zero-latency strobes: exec_en follows inst in the same cycle so ALU ops retire 1/clk.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        mem_req = 1'b0;
        exec_en = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (!halt_op) begin
                        if (mem_op) begin
                            mem_req = 1'b1;
                            exec_en = bus.mem_ack;
                        end else begin
                            exec_en = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    exec_en = bus.mem_ack;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
            wait_cnt    <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (bus.start) begin
                        state       <= RUN;
                        cycle_count <= '0;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    if (halt_op) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else if (mem_op) begin
                        if (bus.mem_ack) begin
                            pc <= pc + 10'd1;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= '0;
                        end
                    end else if (bus.branch_en) begin
                        pc <= bus.lut_target;
                    end else begin
                        pc <= pc + 10'd1;
                    end
                end
                MEM_WAIT: begin
                    cycle_count <= cycle_next;
                    if (bus.mem_ack) begin
                        pc    <= pc + 10'd1;
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // wait_cnt counts un-acked cycles already spent; this is the 255th.
                        if (wait_cnt == WAIT_LIMIT) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                HALT, FAULT: begin
                    if (bus.start) begin
                        state       <= RUN;
                        pc          <= '0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        fault       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lut_key     = bus.inst[4:0];
    assign bus.pc          = pc;
    assign bus.mem_req     = mem_req;
    assign bus.exec_en     = exec_en;
    assign bus.done        = done;
    assign bus.fault       = fault;
    assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential run, branch, memory stall, timeout,
// pc wrap with restart, and reset in the middle of a memory wait.
module tb_fetch_sequencer;

    localparam logic [8:0] ALU_OP  = 9'h001;
    localparam logic [8:0] HALT_OP = 9'h1FF;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   nreq;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.start           = 1'b0;
        bus.inst            = ALU_OP;
        bus.branch_en       = 1'b0;
        bus.memory_read_en  = 1'b0;
        bus.memory_write_en = 1'b0;
        bus.mem_ack         = 1'b0;
        bus.lut_target      = '0;
        tick();
        tick();

        // Reset state
        bus.inst = 9'h1A5;
        settle();
        check("rst_pc", bus.pc, 0);
        check("rst_done", bus.done, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_cycles", bus.cycle_count, 0);
        check("rst_exec", bus.exec_en, 0);
        check("lut_key", bus.lut_key, 5'h05);

        // Sequential run: 3 ALU ops then HALT
        reset     = 1'b0;
        bus.inst  = ALU_OP;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        settle();
        check("seq_pc0", bus.pc, 0);
        check("seq_exec0", bus.exec_en, 1);
        check("seq_memreq0", bus.mem_req, 0);
        tick();
        check("seq_pc1", bus.pc, 1);
        check("seq_exec1", bus.exec_en, 1);
        tick();
        check("seq_pc2", bus.pc, 2);
        check("seq_exec2", bus.exec_en, 1);
        tick();
        check("seq_pc3", bus.pc, 3);
        bus.inst = HALT_OP;
        settle();
        check("seq_halt_exec", bus.exec_en, 0);
        check("seq_done_pre", bus.done, 0);
        tick();
        check("seq_done", bus.done, 1);
        check("seq_cycles", bus.cycle_count, 4);
        check("seq_pc_hold", bus.pc, 3);

        // Branch at pc=2 from a fresh start out of HALT
        bus.inst  = ALU_OP;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("br_restart_pc", bus.pc, 0);
        check("br_restart_done", bus.done, 0);
        tick();
        tick();
        check("br_pc2", bus.pc, 2);
        bus.branch_en  = 1'b1;
        bus.lut_target = 10'h050;
        settle();
        check("br_exec", bus.exec_en, 1);
        tick();
        check("br_target", bus.pc, 10'h050);

        // Memory op with same-cycle ack beats a simultaneous branch
        bus.lut_target     = 10'h123;
        bus.memory_read_en = 1'b1;
        bus.mem_ack        = 1'b1;
        settle();
        check("prio_memreq", bus.mem_req, 1);
        check("prio_exec", bus.exec_en, 1);
        tick();
        check("prio_pc", bus.pc, 10'h051);
        bus.branch_en      = 1'b0;
        bus.memory_read_en = 1'b0;
        bus.mem_ack        = 1'b0;

        // start is ignored in RUN
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_ignored", bus.pc, 10'h052);

        // Branch to 5, then a load that stalls three wait cycles
        bus.branch_en  = 1'b1;
        bus.lut_target = 10'h005;
        tick();
        bus.branch_en = 1'b0;
        check("stall_pc5", bus.pc, 5);
        bus.inst           = 9'h0A3;
        bus.memory_read_en = 1'b1;
        nreq = 0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_ack = (k == 3);
            settle();
            nreq += int'(bus.mem_req);
            check("stall_exec", bus.exec_en, (k == 3) ? 1 : 0);
            check("stall_pc_hold", bus.pc, 5);
            tick();
        end
        bus.memory_read_en = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.inst           = ALU_OP;
        check("stall_memreq_cycles", nreq, 4);
        check("stall_pc6", bus.pc, 6);

        // Store that is never acknowledged
        bus.inst            = 9'h0C7;
        bus.memory_write_en = 1'b1;
        settle();
        check("to_memreq_run", bus.mem_req, 1);
        tick();
        n    = 0;
        nreq = 0;
        while (bus.fault !== 1'b1 && n < 300) begin
            nreq += int'(bus.mem_req);
            tick();
            n++;
        end
        check("to_wait_cycles", n, 255);
        check("to_memreq_cycles", nreq, 255);
        check("to_fault", bus.fault, 1);
        check("to_memreq_off", bus.mem_req, 0);
        check("to_pc_hold", bus.pc, 6);
        check("to_done", bus.done, 0);

        // mem_ack is ignored in FAULT
        bus.mem_ack = 1'b1;
        settle();
        check("fault_ack_exec", bus.exec_en, 0);
        tick();
        check("fault_ack_pc", bus.pc, 6);
        check("fault_stays", bus.fault, 1);
        bus.mem_ack         = 1'b0;
        bus.memory_write_en = 1'b0;

        // Restart from FAULT and run straight-line code through the pc wrap
        bus.inst  = ALU_OP;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("wrap_start_pc", bus.pc, 0);
        check("wrap_start_fault", bus.fault, 0);
        check("wrap_start_cycles", bus.cycle_count, 0);
        for (int k = 0; k < 1023; k++) tick();
        check("wrap_pc_3ff", bus.pc, 10'h3FF);
        tick();
        check("wrap_pc_0", bus.pc, 0);
        bus.inst = HALT_OP;
        tick();
        check("wrap_done", bus.done, 1);
        check("wrap_cycles", bus.cycle_count, 1025);

        // HALT ignores memory traffic and holds cycle_count
        bus.memory_read_en = 1'b1;
        bus.mem_ack        = 1'b1;
        settle();
        check("halt_memreq", bus.mem_req, 0);
        check("halt_exec", bus.exec_en, 0);
        tick();
        check("halt_cycles_hold", bus.cycle_count, 1025);
        bus.memory_read_en = 1'b0;
        bus.mem_ack        = 1'b0;

        bus.inst  = ALU_OP;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_pc", bus.pc, 0);
        check("restart_cycles", bus.cycle_count, 0);
        check("restart_done", bus.done, 0);

        // Reset in the middle of MEM_WAIT, with start asserted alongside it
        tick();
        tick();
        check("rmw_pc2", bus.pc, 2);
        bus.memory_read_en = 1'b1;
        tick();
        check("rmw_memreq", bus.mem_req, 1);
        tick();
        reset     = 1'b1;
        bus.start = 1'b1;
        settle();
        check("rmw_memreq_in_reset", bus.mem_req, 0);
        check("rmw_exec_in_reset", bus.exec_en, 0);
        tick();
        check("rmw_pc", bus.pc, 0);
        check("rmw_cycles", bus.cycle_count, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        settle();
        check("rmw_idle_memreq", bus.mem_req, 0);
        check("rmw_idle_exec", bus.exec_en, 0);
        bus.memory_read_en = 1'b0;
        tick();
        check("idle_pc_hold", bus.pc, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        settle();
        check("resume_pc0", bus.pc, 0);
        check("resume_exec", bus.exec_en, 1);
        tick();
        check("resume_pc1", bus.pc, 1);
        check("resume_cycles", bus.cycle_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input is permitted.
REQ-002 The block SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins execution from PC 0
- inst  in  9  instruction at address pc, combinational from instruction ROM
- branch_en  in  1  branch taken, from instruction decoder
- memory_read_en  in  1  load decoded, from instruction decoder
- memory_write_en  in  1  store decoded, from instruction decoder
- mem_ack  in  1  data memory completion strobe
- lut_target  in  10  branch target returned by the branch LUT for lut_key
- lut_key  out  5  branch LUT index, equal to inst[4:0] at all times (combinational)
- pc  out  10  program counter (registered)
- mem_req  out  1  data memory request (combinational from state and inputs)
- exec_en  out  1  retire strobe; gates register-file and memory writes this cycle
- done  out  1  high while in HALT (registered state decode)
- fault  out  1  high while in FAULT (registered state decode)
- cycle_count  out  16  execution cycles since the last start

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RUN, MEM_WAIT, HALT and FAULT.
REQ-004 IDLE: pc=0, mem_req=0, exec_en=0; start=1 -> RUN, with pc held at 0 and cycle_count cleared to 0.
REQ-005 RUN, inst==9'h1FF (HALT opcode): exec_en=0, mem_req=0, pc holds, next state HALT.
REQ-006 RUN, memory_read_en or memory_write_en high: mem_req=1; if mem_ack is high the same cycle, exec_en=1, pc<=pc+1 and the FSM stays in RUN; otherwise exec_en=0, pc holds and next state is MEM_WAIT.
REQ-007 RUN, all other instructions: exec_en=1; pc<=lut_target if branch_en, else pc<=pc+1.
REQ-008 When a memory op and branch_en are both high, the memory op SHALL take priority and branch_en SHALL be ignored.
REQ-009 MEM_WAIT: mem_req=1; on mem_ack, exec_en=1, pc<=pc+1 and the FSM returns to RUN; otherwise exec_en=0 and pc holds.
REQ-010 An 8-bit wait counter SHALL clear on every entry to MEM_WAIT and increment each MEM_WAIT cycle without ack; after 255 consecutive un-acked MEM_WAIT cycles, next state is FAULT with mem_req deasserted.
REQ-011 HALT and FAULT: mem_req=0, exec_en=0, pc holds; start=1 -> RUN with pc<=0 and cycle_count<=0.
REQ-012 start SHALL be ignored in RUN and MEM_WAIT.
REQ-013 pc+1 SHALL wrap from 10'h3FF to 10'h000 with no flag.
REQ-014 cycle_count SHALL increment by 1 every cycle spent in RUN or MEM_WAIT and saturate at 16'hFFFF; it holds in IDLE, HALT and FAULT.
REQ-015 Single-cycle instructions SHALL retire at 1 instruction per clock, with zero-cycle latency from inst to exec_en.
REQ-016 mem_ack received outside RUN-with-memory-op or MEM_WAIT SHALL be ignored.

Reset
REQ-017 reset=1 SHALL force, at the next edge and regardless of state (including mid MEM_WAIT): state=IDLE, pc=0, cycle_count=0, wait counter=0, done=0, fault=0.
REQ-018 While reset is high, mem_req and exec_en SHALL be 0, and reset SHALL take priority over start.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Sequential run: reset, start; ROM holds 3 ALU ops then 9'h1FF -> exec_en high 3 cycles, pc 0,1,2,3; done=1 on the 5th edge after start; cycle_count=4.
- Branch: inst at pc=2 with branch_en=1, lut_target=10'h050 -> pc=10'h050 next cycle, exec_en=1 in the branch cycle.
- Memory stall: load at pc=5, mem_ack after 3 wait cycles -> mem_req high 4 cycles, exec_en high only in the ack cycle, then pc=6.
- Timeout: store, mem_ack never asserted -> fault=1 after 255 MEM_WAIT cycles, mem_req=0, pc holds at the store address.
- Wrap and restart: straight-line code running to pc=10'h3FF -> pc=0 next; then start from HALT -> pc=0, cycle_count=0.
- Reset mid MEM_WAIT -> next cycle IDLE, pc=0, mem_req=0; a subsequent start resumes from pc=0.
